// File: rtl/vending_machine_pkg.sv
// Shared definitions for the single-product vending controller.
//   - state_e    : stored credit (0, 5 or 10 units); encodings equal the credit value
//   - COIN_*     : coin-acceptor input codes
//   - CHG_*      : change/refund output codes
//   - PRICE      : product price, used by the embedded checks
//   - credit_of / coin_value : helpers that turn codes into unit values
package vending_machine_pkg;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S5  = 4'd5,
    S10 = 4'd10
  } state_e;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  localparam int unsigned PRICE = 15;

  function automatic int unsigned credit_of(input state_e s);
    case (s)
      S5:      credit_of = 5;
      S10:     credit_of = 10;
      default: credit_of = 0;
    endcase
  endfunction

  function automatic int unsigned coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = 5;
      COIN_10: coin_value = 10;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Coin-operated vending controller, price 15, accepts 5- and 10-unit coins.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset (clears credit and outputs)
//   in     - coin code: 00 none, 01 five, 10 ten, 11 cancel/ignored
//   out    - registered one-cycle dispense pulse
//   change - registered change code: 00 none, 01 return 5, 10 return 10
//
// Build option:
//   VENDING_CANCEL_EN - when defined, in=11 refunds the stored credit and
//                       returns to S0; otherwise in=11 behaves like no coin.
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  state_e     state_q, state_d;
  logic       out_d;
  logic [1:0] change_d;

  // Any code that does not match a coin (including X/Z) falls through the
  // default arms and holds credit with quiet outputs.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = CHG_NONE;
    case (state_q)
      S0: begin
        case (in)
          COIN_5:  state_d = S5;
          COIN_10: state_d = S10;
          default: ;
        endcase
      end
      S5: begin
        case (in)
          COIN_5:  state_d = S10;
          COIN_10: begin
            state_d = S0;
            out_d   = 1'b1;
          end
`ifdef VENDING_CANCEL_EN
          COIN_CANCEL: begin
            state_d  = S0;
            change_d = CHG_5;
          end
`endif
          default: ;
        endcase
      end
      S10: begin
        case (in)
          COIN_5: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          COIN_10: begin
            // 20 units: vend and hand back the surplus in the same cycle.
            state_d  = S0;
            out_d    = 1'b1;
            change_d = CHG_5;
          end
`ifdef VENDING_CANCEL_EN
          COIN_CANCEL: begin
            state_d  = S0;
            change_d = CHG_10;
          end
`endif
          default: ;
        endcase
      end
      default: begin
        // Corrupted encoding: drop to empty credit, no actuation.
        state_d = S0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      out     <= 1'b0;
      change  <= CHG_NONE;
    end else begin
      state_q <= state_d;
      out     <= out_d;
      change  <= change_d;
    end
  end

  // A vend must be backed by real credit plus the coin just inserted; since a
  // vend always leaves S0 behind, this also rules out spurious back-to-back
  // pulses.
  a_vend_funded: assert property (@(posedge clk) disable iff (!rst)
    out_d |-> (credit_of(state_q) + coin_value(in) >= PRICE));

  a_change_legal: assert property (@(posedge clk) disable iff (!rst)
    change != 2'b11);

endmodule

// File: tb/tb_vending_machine.sv
// Directed testbench for vending_machine. A small credit model predicts each
// cycle's {out, change}; predictions are queued when a coin is driven and
// popped for comparison after the following rising edge.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned credit = 0;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } item_t;

  item_t sb[$];

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed={out,change}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Independent model: accumulate unit value, vend at >= 15, refund surplus.
  function automatic logic [2:0] predict(input logic [1:0] coin);
    logic [2:0] r;
    r = 3'b000;
    if (coin === 2'b01) credit = credit + 5;
    else if (coin === 2'b10) credit = credit + 10;
`ifdef VENDING_CANCEL_EN
    else if (coin === 2'b11) begin
      if (credit == 5) r = 3'b001;
      else if (credit == 10) r = 3'b010;
      credit = 0;
    end
`endif
    if (credit >= 15) begin
      r = {1'b1, (credit == 20) ? 2'b01 : 2'b00};
      credit = 0;
    end
    return r;
  endfunction

  task automatic step(input logic [1:0] coin, input string tag);
    item_t it;
    it.tag = tag;
    it.exp = predict(coin);
    sb.push_back(it);
    in = coin;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      it = sb.pop_front();
      check(it.tag, {out, change}, it.exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 2'b01;
    // Coins presented during reset must be ignored.
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", {out, change}, 3'b000);
    end
    rst = 1'b1;
    credit = 0;
    repeat (3) step(2'b00, "idle");

    step(2'b01, "five_1");
    step(2'b01, "five_2");
    step(2'b01, "five_3_vend");
    step(2'b00, "five_after");

    step(2'b10, "ten_1");
    step(2'b10, "ten_2_vend_chg");
    step(2'b00, "ten_after");

    step(2'b01, "5_10_a");
    step(2'b10, "5_10_vend");
    step(2'b10, "10_5_a");
    step(2'b01, "10_5_vend");

    // Credit held across idle cycles, then discarded by an async reset.
    step(2'b10, "hold_ten");
    repeat (5) step(2'b00, "hold_idle");
    #2 rst = 1'b0;
    #1 check("rst_async_idle", {out, change}, 3'b000);
    credit = 0;
    #2 rst = 1'b1;
    step(2'b01, "post_rst_five_no_vend");
    step(2'b00, "post_rst_idle");

    // Reset while the dispense pulse is high clears it without an edge.
    step(2'b10, "vend_before_rst");
    #2 rst = 1'b0;
    #1 check("rst_async_vend", {out, change}, 3'b000);
    credit = 0;
    #2 rst = 1'b1;

    // Unknown coin code holds credit.
    step(2'b01, "x_pre");
    step(2'bxx, "x_hold");
    step(2'b10, "x_post_vend");

    // Cancel code: refund if enabled, otherwise ignored with credit kept.
    step(2'b10, "cancel_pre");
    step(2'b11, "cancel");
    step(2'b01, "cancel_post");
    step(2'b00, "cancel_idle");
    step(2'b11, "cancel_from_s0");
    step(2'b00, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
